// File: rtl/fft_axi_pkg.sv
// Shared constants and read-FSM state type for the FFT result read path.
package fft_axi_pkg;

  localparam int N_PT      = 128;
  localparam int LOG2_N_PT = 7;
  localparam int SAMPLE_W  = 16;

  localparam logic [LOG2_N_PT-1:0] LAST_IDX   = LOG2_N_PT'(N_PT - 1);
  localparam logic [1:0]           RESP_OKAY  = 2'b00;
  localparam logic [1:0]           BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_BURST = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fft_frame_ram.sv
// Frame buffer: one write port and one registered read port with read enable.
module fft_frame_ram
  import fft_axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = N_PT,
  parameter int AW    = LOG2_N_PT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // The read register doubles as the R data output, so it resets to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_result_rd_buffer.sv
// Captures one FFT output frame and serves it over an AXI4 INCR read channel.
module fft_result_rd_buffer
  import fft_axi_pkg::*;
#(
  parameter int WIDTH_SID = 15,
  parameter int WIDTH_AD  = 14,
  parameter int WIDTH_DA  = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 fft_valid,
  input  logic [SAMPLE_W-1:0]  fft_real,
  input  logic [SAMPLE_W-1:0]  fft_imag,
  input  logic [WIDTH_SID-1:0] S_AXI_ARID,
  input  logic [WIDTH_AD-1:0]  S_AXI_ARADDR,
  input  logic [7:0]           S_AXI_ARLEN,
  input  logic [2:0]           S_AXI_ARSIZE,
  input  logic [1:0]           S_AXI_ARBURST,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  output logic [WIDTH_SID-1:0] S_AXI_RID,
  output logic [WIDTH_DA-1:0]  S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RLAST,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic                 frame_ready,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output rd_state_t            dbg_rd_state
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both 1; once asserted, RVALID/RDATA/RLAST/RID stay fixed until RREADY.

  logic [LOG2_N_PT-1:0] r_wr_cnt;
  logic                 r_frame_ready;
  logic                 r_overflow;
  rd_state_t            r_state;
  rd_state_t            w_next;
  logic [WIDTH_SID-1:0] r_rid;
  logic [7:0]           r_beats;
  logic [LOG2_N_PT-1:0] r_idx;

  logic                 w_cap;
  logic                 w_drop;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_last;
  logic                 w_release;
  logic                 w_rd_en;
  logic [LOG2_N_PT-1:0] w_rd_addr;
  logic                 w_unused;

  // Size, burst type and out-of-frame address bits do not affect the beat stream.
  assign w_unused = ^{S_AXI_ARSIZE, S_AXI_ARBURST,
                      S_AXI_ARADDR[WIDTH_AD-1:9], S_AXI_ARADDR[1:0]};

  assign w_cap     = fft_valid && !r_frame_ready;
  assign w_drop    = fft_valid && r_frame_ready;
  assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_r_hs    = S_AXI_RVALID && S_AXI_RREADY;
  assign w_last    = (r_state == RD_BURST) && (r_beats == 8'd0);
  assign w_release = w_r_hs && w_last && (r_idx == LAST_IDX);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_cnt      <= '0;
      r_frame_ready <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_cap) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_cnt == LAST_IDX) r_frame_ready <= 1'b1;
      end else if (w_release) begin
        r_frame_ready <= 1'b0;
      end
      // A drop in the same cycle as a clear wins so no overflow event is lost.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_addr = r_idx;
    case (r_state)
      RD_IDLE: begin
        if (w_ar_hs) w_next = RD_FETCH;
      end
      RD_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = RD_BURST;
      end
      RD_BURST: begin
        if (w_r_hs) begin
          if (w_last) begin
            w_next = RD_IDLE;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_idx + 1'b1;
          end
        end
      end
      default: w_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= RD_IDLE;
      r_rid   <= '0;
      r_beats <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_ar_hs) begin
        r_rid   <= S_AXI_ARID;
        r_beats <= S_AXI_ARLEN;
        r_idx   <= S_AXI_ARADDR[8:2];
      end else if (w_r_hs && !w_last) begin
        r_beats <= r_beats - 8'd1;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  fft_frame_ram #(
    .WIDTH (WIDTH_DA),
    .DEPTH (N_PT),
    .AW    (LOG2_N_PT)
  ) u_ram (
    .i_clk     (S_AXI_ACLK),
    .i_rst_n   (S_AXI_ARESETN),
    .i_wr_en   (w_cap),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data ({fft_real, fft_imag}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (S_AXI_RDATA)
  );

  assign S_AXI_ARREADY = (r_state == RD_IDLE) && r_frame_ready;
  assign S_AXI_RVALID  = (r_state == RD_BURST);
  assign S_AXI_RLAST   = w_last;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign frame_ready   = r_frame_ready;
  assign overflow      = r_overflow;
  assign dbg_rd_state  = r_state;

endmodule

// File: tb/tb_fft_result_rd_buffer.sv
// Directed bench for fft_result_rd_buffer: capture, bursts, stalls, overflow, reset abort.
module tb_fft_result_rd_buffer;
  import fft_axi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        fft_valid;
  logic [15:0] fft_real;
  logic [15:0] fft_imag;
  logic [14:0] arid;
  logic [13:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [14:0] rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        frame_ready;
  logic        overflow;
  logic        ovf_clr;
  rd_state_t   dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_mem [128];
  logic [31:0] exp_q [$];

  fft_result_rd_buffer dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .fft_valid     (fft_valid),
    .fft_real      (fft_real),
    .fft_imag      (fft_imag),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (arsize),
    .S_AXI_ARBURST (arburst),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .frame_ready   (frame_ready),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .dbg_rd_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample k of a frame is real=base+k, imag=-(base+k).
  task automatic feed_frame(input logic [15:0] base);
    logic [15:0] v;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      v         = base + 16'(i);
      fft_valid = 1'b1;
      fft_real  = v;
      fft_imag  = 16'd0 - v;
      exp_mem[i] = {v, 16'd0 - v};
      if (i == 127) check("frame_ready_before_last", {31'd0, frame_ready}, 32'd0);
    end
    @(negedge clk);
    fft_valid = 1'b0;
    check("frame_ready_after_last", {31'd0, frame_ready}, 32'd1);
  endtask

  task automatic extra_samples(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fft_valid = 1'b1;
      ovf_clr   = clr;
      fft_real  = 16'hAAAA;
      fft_imag  = 16'h5555;
    end
    @(negedge clk);
    fft_valid = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  // mode 0: RREADY held high; mode 1: RREADY toggles starting low.
  task automatic read_burst(input logic [13:0] addr, input logic [7:0] len,
                            input logic [14:0] id, input int mode,
                            input int abort_at, input bit valid_on_last);
    logic [6:0]  idx;
    logic [31:0] hold_data;
    logic        hold_last;
    logic        stalled;
    logic        rr;
    logic        tgl;
    int          beats;
    int          cycles;
    int          cnt;
    exp_q.delete();
    idx = addr[8:2];
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(exp_mem[idx]);
      idx = idx + 7'd1;
    end
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
    arsize  = 3'b010; arburst = 2'b01;
    cnt = 0;
    while (!arready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_fetch", {31'd0, rvalid}, 32'd0);
    check("arready_busy", {31'd0, arready}, 32'd0);
    @(negedge clk);
    check("rvalid_first", {31'd0, rvalid}, 32'd1);
    beats = 0; cycles = 0; stalled = 1'b0; tgl = 1'b0;
    while (beats <= int'(len) && cycles < 4 * (int'(len) + 1) + 8) begin
      if (beats == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_rvalid", {31'd0, rvalid}, 32'd0);
        check("abort_frame_ready", {31'd0, frame_ready}, 32'd0);
        check("abort_arready", {31'd0, arready}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_rid", {17'd0, rid}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rready = 1'b0;
        return;
      end
      rr     = (mode == 0) ? 1'b1 : tgl;
      tgl    = ~tgl;
      rready = rr;
      if (stalled) begin
        check("stall_rvalid", {31'd0, rvalid}, 32'd1);
        check("stall_rdata", rdata, hold_data);
        check("stall_rlast", {31'd0, rlast}, {31'd0, hold_last});
      end
      if (rvalid && rr) begin
        check("rdata", rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX);
        check("rlast", {31'd0, rlast}, (beats == int'(len)) ? 32'd1 : 32'd0);
        check("rid", {17'd0, rid}, {17'd0, id});
        check("rresp", {30'd0, rresp}, 32'd0);
        if (valid_on_last && beats == int'(len)) begin
          fft_valid = 1'b1; fft_real = 16'hDEAD; fft_imag = 16'hBEEF;
        end
        beats++;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled   = 1'b1;
        hold_data = rdata;
        hold_last = rlast;
      end
      @(negedge clk);
      fft_valid = 1'b0;
      cycles++;
    end
    rready = 1'b0;
    check("beat_count", beats, int'(len) + 1);
    if (mode == 0) check("back_to_back", cycles, int'(len) + 1);
    check("rvalid_after", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fft_valid = 1'b0; fft_real = '0; fft_imag = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b0; rready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rlast", {31'd0, rlast}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rid", {17'd0, rid}, 32'd0);
    check("rst_rresp", {30'd0, rresp}, 32'd0);
    check("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_arready", {31'd0, arready}, 32'd0);

    // Frame A: real=i, imag=-i
    feed_frame(16'd0);
    check("ovf_after_capture", {31'd0, overflow}, 32'd0);

    // Wrapping burst across index 127 -> 0; frame must survive
    read_burst(14'h1F8, 8'd3, 15'h5A5A, 0, -1, 1'b0);
    check("wrap_keeps_frame", {31'd0, frame_ready}, 32'd1);

    // Drops while frame pending
    extra_samples(5, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    extra_samples(1, 1'b1);
    check("ovf_drop_and_clr", {31'd0, overflow}, 32'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    read_burst(14'h010, 8'd1, 15'h0003, 0, -1, 1'b0);

    // Stalled short burst, then full releasing burst with a colliding sample
    read_burst(14'h040, 8'd15, 15'h1234, 1, -1, 1'b0);
    check("stall_keeps_frame", {31'd0, frame_ready}, 32'd1);
    read_burst(14'h000, 8'd127, 15'h7FFF, 0, -1, 1'b1);
    check("release_frame_ready", {31'd0, frame_ready}, 32'd0);
    check("release_drop_ovf", {31'd0, overflow}, 32'd1);

    // Frame B starts at index 0 with its own first sample
    feed_frame(16'h0200);
    read_burst(14'h000, 8'd127, 15'h0011, 1, -1, 1'b0);
    check("release_b", {31'd0, frame_ready}, 32'd0);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_cleared_b", {31'd0, overflow}, 32'd0);

    // Reset during a burst, then a clean frame afterwards
    feed_frame(16'h0300);
    read_burst(14'h000, 8'd127, 15'h0022, 0, 40, 1'b0);
    check("post_abort_overflow", {31'd0, overflow}, 32'd0);
    check("post_abort_arready", {31'd0, arready}, 32'd0);
    feed_frame(16'h0400);
    read_burst(14'h000, 8'd127, 15'h0033, 0, -1, 1'b0);
    check("release_d", {31'd0, frame_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
